// File: rtl/systolic_result_drain_if.sv
// Result stream port of the systolic drain: one word per val/rdy handshake.
interface systolic_result_drain_if #(
    parameter int unsigned data_bits = 32
) ();
    logic [data_bits-1:0] send_msg;
    logic                 send_val;
    logic                 send_rdy;
    logic                 send_last;

    // Producer side (the drain block).
    modport master (
        output send_msg,
        output send_val,
        output send_last,
        input  send_rdy
    );

    // Consumer side.
    modport slave (
        input  send_msg,
        input  send_val,
        input  send_last,
        output send_rdy
    );
endinterface

// File: rtl/systolic_result_drain.sv
// Waits out the wavefront settle time after mac_en, snapshots every PE
// accumulator in one cycle, then streams them row-major over a val/rdy port.
module systolic_result_drain #(
    parameter int unsigned size          = 4,
    parameter int unsigned data_bits     = 32,
    parameter int unsigned settle_cycles = 3 * size
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              mac_en,
    input  logic [size*size*data_bits-1:0]    results,
    systolic_result_drain_if.master           send,
    output logic                              done
);
    localparam int unsigned NUM_WORDS = size * size;
    localparam int unsigned CNT_W     = $clog2(settle_cycles + 1);
    localparam int unsigned IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(settle_cycles - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WORDS - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     idx_nxt;
    logic                 snap_load;
    logic [data_bits-1:0] snap [NUM_WORDS];

    // Next-state, counter and snapshot-load decode.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        snap_load = 1'b0;
        case (state)
            S_IDLE: begin
                if (mac_en) begin
                    state_nxt = S_SETTLE;
                    cnt_nxt   = '0;
                end
            end
            S_SETTLE: begin
                if (!mac_en) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    snap_load = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = S_STREAM;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_STREAM: begin
                // send_val is high throughout STREAM, so rdy alone is the handshake.
                if (send.send_rdy) begin
                    if (idx == IDX_LAST) begin
                        state_nxt = S_DONE;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            S_DONE: begin
                if (!mac_en) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
        end
    end

    // Snapshot of the whole accumulator bus, frozen until the next pass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_WORDS); i++) begin
                snap[i] <= '0;
            end
        end else if (snap_load) begin
            for (int i = 0; i < int'(NUM_WORDS); i++) begin
                snap[i] <= results[i*data_bits +: data_bits];
            end
        end
    end

    // Stream outputs decoded directly from registers, no added latency.
    assign send.send_val  = (state == S_STREAM);
    assign send.send_msg  = snap[idx];
    assign send.send_last = (state == S_STREAM) && (idx == IDX_LAST);
    assign done           = (state == S_DONE);
endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed scoreboard bench for systolic_result_drain (size=2, 8-bit, settle=4).
module tb_systolic_result_drain;
    localparam int unsigned SIZE   = 2;
    localparam int unsigned DBITS  = 8;
    localparam int unsigned SETTLE = 4;
    localparam int unsigned NW     = SIZE * SIZE;

    typedef struct packed {
        logic [DBITS-1:0] msg;
        logic             last;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    mac_en = 1'b0;
    logic [NW*DBITS-1:0]     results = '0;
    logic                    done;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    systolic_result_drain_if #(.data_bits(DBITS)) sif ();

    systolic_result_drain #(
        .size          (SIZE),
        .data_bits     (DBITS),
        .settle_cycles (SETTLE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .mac_en  (mac_en),
        .results (results),
        .send    (sif.master),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Load results and push the expected row-major drain into the scoreboard.
    task automatic load_results(input logic [NW*DBITS-1:0] r);
        results = r;
        for (int i = 0; i < int'(NW); i++) begin
            exp_t e;
            e.msg  = r[i*DBITS +: DBITS];
            e.last = (i == int'(NW) - 1);
            sb.push_back(e);
        end
    endtask

    // Raise mac_en at a negedge and check send_val stays low until snapshot+1.
    task automatic start_pass();
        mac_en = 1'b1;
        @(posedge clk);
        for (int i = 0; i < int'(SETTLE); i++) begin
            @(negedge clk);
            chk("val_before_snapshot", 32'(sif.send_val), 32'd0);
            @(posedge clk);
        end
    endtask

    // Drain words from the DUT; mode 0 = rdy always 1, mode 1 = rdy 0,1,0,0,1 ...
    // Returns at the negedge where handshake number stop_after is detected.
    task automatic drain(input int mode, input int stop_after, input bit poison,
                         output int cycles);
        int               n = 0;
        bit               held = 1'b0;
        logic [DBITS-1:0] hmsg = '0;
        logic             hlast = 1'b0;
        int               pat[5] = '{0, 1, 0, 0, 1};
        exp_t             e;
        cycles = 0;
        while (n < stop_after && cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (poison && cycles == 1) results = '1;
            sif.send_rdy = (mode == 0) ? 1'b1 : pat[(cycles - 1) % 5][0];
            chk("send_val_in_stream", 32'(sif.send_val), 32'd1);
            if (held) begin
                chk("msg_stable_under_bp", 32'(sif.send_msg), 32'(hmsg));
                chk("last_stable_under_bp", 32'(sif.send_last), 32'(hlast));
            end
            if (sif.send_val && sif.send_rdy) begin
                n++;
                held = 1'b0;
                if (sb.size() == 0) begin
                    chk("scoreboard_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("send_msg", 32'(sif.send_msg), 32'(e.msg));
                    chk("send_last", 32'(sif.send_last), 32'(e.last));
                end
            end else begin
                held  = sif.send_val;
                hmsg  = sif.send_msg;
                hlast = sif.send_last;
            end
        end
        chk("drain_within_budget", 32'(n), 32'(stop_after));
    endtask

    // After the final handshake edge, done must be up and val down.
    task automatic check_done();
        @(posedge clk);
        @(negedge clk);
        sif.send_rdy = 1'b0;
        chk("done_after_last", 32'(done), 32'd1);
        chk("val_low_in_done", 32'(sif.send_val), 32'd0);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic drop_mac();
        mac_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("done_falls", 32'(done), 32'd0);
    endtask

    initial begin
        int cyc;
        sif.send_rdy = 1'b0;

        // Reset state.
        #1;
        chk("rst_val", 32'(sif.send_val), 32'd0);
        chk("rst_last", 32'(sif.send_last), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_msg", 32'(sif.send_msg), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Basic drain at full throughput: four consecutive words.
        load_results(32'h44332211);
        start_pass();
        drain(0, 4, 1'b0, cyc);
        chk("full_rate_cycles", 32'(cyc), 32'd4);
        check_done();
        drop_mac();

        // Backpressure with results poisoned right after the snapshot.
        @(negedge clk);
        load_results(32'h44332211);
        start_pass();
        drain(1, 4, 1'b1, cyc);
        check_done();
        drop_mac();

        // Abort in SETTLE: 3 sampled cycles of mac_en produce nothing.
        results = 32'h44332211;
        mac_en  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        mac_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("abort_no_val", 32'(sif.send_val), 32'd0);
            chk("abort_no_done", 32'(done), 32'd0);
        end

        // Full pulse after the abort drains normally, then DONE holds.
        load_results(32'h44332211);
        start_pass();
        drain(0, 4, 1'b0, cyc);
        check_done();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            sif.send_rdy = 1'b1;
            chk("hold_no_second_drain", 32'(sif.send_val), 32'd0);
            chk("hold_done", 32'(done), 32'd1);
        end
        sif.send_rdy = 1'b0;
        drop_mac();

        // Rearm with new results.
        load_results(32'h04030201);
        start_pass();
        drain(0, 4, 1'b0, cyc);
        check_done();
        drop_mac();

        // Async reset mid-stream after two transfers.
        load_results(32'h44332211);
        start_pass();
        drain(0, 2, 1'b0, cyc);
        @(posedge clk);
        #1;
        chk("pre_reset_msg", 32'(sif.send_msg), 32'h33);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_val", 32'(sif.send_val), 32'd0);
        chk("async_rst_last", 32'(sif.send_last), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        chk("async_rst_msg", 32'(sif.send_msg), 32'd0);
        sb.delete();
        mac_en = 1'b0;
        sif.send_rdy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_idle_val", 32'(sif.send_val), 32'd0);
        chk("post_reset_idle_done", 32'(done), 32'd0);

        // Restart from IDLE with a full pass.
        load_results(32'hA5B6C7D8);
        start_pass();
        drain(0, 4, 1'b0, cyc);
        check_done();
        drop_mac();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
